// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
//   Shared decode types for the core pipeline: ALU operation codes, write-back
//   select, RV32I opcode values, the decoded control word carried from decode
//   to execute, and the decode-stage occupancy state.
// ----------------------------------------------------------------------------
package ctrl_pkg;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_SLL    = 5'd2,
      ALU_SLT    = 5'd3,
      ALU_SLTU   = 5'd4,
      ALU_XOR    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_OR     = 5'd8,
      ALU_AND    = 5'd9,
      ALU_PASSB  = 5'd10,
      ALU_MUL    = 5'd16,
      ALU_MULH   = 5'd17,
      ALU_MULHSU = 5'd18,
      ALU_MULHU  = 5'd19,
      ALU_DIV    = 5'd20,
      ALU_DIVU   = 5'd21,
      ALU_REM    = 5'd22,
      ALU_REMU   = 5'd23
   } alu_op_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MEXT = 7'b0000001;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      alu_op_e    alu_op;
      logic       alu_src_imm;
      logic       alu_src_pc;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic [2:0] mem_size;
      logic       branch;
      logic [2:0] br_cond;
      logic       jump;
      wb_sel_e    wb_sel;
      logic       illegal;
   } ctrl_word_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } pipe_state_e;

   // Base-ISA ALU op selected by funct3; alt picks SUB / SRA.
   function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
      alu_op_e op;
      case (funct3)
         3'd0:    op = alt ? ALU_SUB : ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    op = alt ? ALU_SRA : ALU_SRL;
         3'd6:    op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/control_decode_comb.sv
// ----------------------------------------------------------------------------
// control_decode_comb
//   Pure combinational RV32I (+ optional M) decoder: instruction word in,
//   control word and sign-extended immediate out. No state.
//   Ports:
//     instr  in   32    raw instruction word
//     ctrl   out  -     decoded control word (ctrl_word_t)
//     imm    out  XLEN  immediate sign-extended from instr[31]; 0 for R-type
// ----------------------------------------------------------------------------
module control_decode_comb
   import ctrl_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int EN_MEXT = 0
) (
   input  logic [31:0]     instr,
   output ctrl_word_t      ctrl,
   output logic [XLEN-1:0] imm
);

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;

   logic signed [31:0] w_imm_i;
   logic signed [31:0] w_imm_s;
   logic signed [31:0] w_imm_b;
   logic signed [31:0] w_imm_u;
   logic signed [31:0] w_imm_j;
   logic signed [31:0] w_imm32;
   logic               w_illegal;

   assign w_opcode = instr[6:0];
   assign w_funct3 = instr[14:12];
   assign w_funct7 = instr[31:25];

   assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
   assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign w_imm_u = {instr[31:12], 12'b0};
   assign w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      ctrl      = '0;
      ctrl.rs1  = instr[19:15];
      ctrl.rs2  = instr[24:20];
      ctrl.rd   = instr[11:7];
      w_imm32   = '0;
      w_illegal = 1'b0;

      case (w_opcode)
         OPC_LUI: begin
            ctrl.rs1         = '0;
            ctrl.rs2         = '0;
            w_imm32          = w_imm_u;
            ctrl.alu_op      = ALU_PASSB;
            ctrl.alu_src_imm = 1'b1;
            ctrl.reg_write   = 1'b1;
         end
         OPC_AUIPC: begin
            ctrl.rs1         = '0;
            ctrl.rs2         = '0;
            w_imm32          = w_imm_u;
            ctrl.alu_op      = ALU_ADD;
            ctrl.alu_src_pc  = 1'b1;
            ctrl.alu_src_imm = 1'b1;
            ctrl.reg_write   = 1'b1;
         end
         OPC_JAL: begin
            ctrl.rs1         = '0;
            ctrl.rs2         = '0;
            w_imm32          = w_imm_j;
            ctrl.alu_op      = ALU_ADD;
            ctrl.alu_src_pc  = 1'b1;
            ctrl.alu_src_imm = 1'b1;
            ctrl.jump        = 1'b1;
            ctrl.wb_sel      = WB_PC4;
            ctrl.reg_write   = 1'b1;
         end
         OPC_JALR: begin
            ctrl.rs2         = '0;
            w_imm32          = w_imm_i;
            ctrl.alu_op      = ALU_ADD;
            ctrl.alu_src_imm = 1'b1;
            ctrl.jump        = 1'b1;
            ctrl.wb_sel      = WB_PC4;
            ctrl.reg_write   = 1'b1;
            w_illegal        = (w_funct3 != 3'd0);
         end
         OPC_BRANCH: begin
            ctrl.rd      = '0;
            w_imm32      = w_imm_b;
            ctrl.alu_op  = ALU_SUB;
            ctrl.branch  = 1'b1;
            ctrl.br_cond = w_funct3;
            w_illegal    = (w_funct3 == 3'd2) || (w_funct3 == 3'd3);
         end
         OPC_LOAD: begin
            ctrl.rs2         = '0;
            w_imm32          = w_imm_i;
            ctrl.alu_op      = ALU_ADD;
            ctrl.alu_src_imm = 1'b1;
            ctrl.mem_read    = 1'b1;
            ctrl.mem_size    = w_funct3;
            ctrl.wb_sel      = WB_MEM;
            ctrl.reg_write   = 1'b1;
            // LB LH LW LBU LHU only; 64-bit and reserved widths are rejected.
            w_illegal        = (w_funct3 == 3'd3) || (w_funct3 == 3'd6) || (w_funct3 == 3'd7);
         end
         OPC_STORE: begin
            ctrl.rd          = '0;
            w_imm32          = w_imm_s;
            ctrl.alu_op      = ALU_ADD;
            ctrl.alu_src_imm = 1'b1;
            ctrl.mem_write   = 1'b1;
            ctrl.mem_size    = w_funct3;
            w_illegal        = (w_funct3 > 3'd2);
         end
         OPC_OPIMM: begin
            ctrl.rs2         = '0;
            w_imm32          = w_imm_i;
            // Only shifts carry a funct7; for the rest instr[30] is immediate.
            ctrl.alu_op      = alu_from_funct3(w_funct3, (w_funct3 == 3'd5) && instr[30]);
            ctrl.alu_src_imm = 1'b1;
            ctrl.reg_write   = 1'b1;
            if (w_funct3 == 3'd1)
               w_illegal = (w_funct7 != F7_BASE);
            else if (w_funct3 == 3'd5)
               w_illegal = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
         end
         OPC_OP: begin
            ctrl.reg_write = 1'b1;
            if (w_funct7 == F7_BASE) begin
               ctrl.alu_op = alu_from_funct3(w_funct3, 1'b0);
            end else if (w_funct7 == F7_ALT) begin
               ctrl.alu_op = alu_from_funct3(w_funct3, 1'b1);
               w_illegal   = (w_funct3 != 3'd0) && (w_funct3 != 3'd5);
            end else if ((w_funct7 == F7_MEXT) && (EN_MEXT != 0)) begin
               // MUL..REMU occupy 16 + funct3.
               ctrl.alu_op = alu_op_e'({2'b10, w_funct3});
            end else begin
               w_illegal = 1'b1;
            end
         end
         default: w_illegal = 1'b1;
      endcase

      // Compressed/16-bit encodings (which includes the all-zero word).
      if (instr[1:0] != 2'b11)
         w_illegal = 1'b1;

      if (w_illegal) begin
         ctrl.reg_write = 1'b0;
         ctrl.mem_read  = 1'b0;
         ctrl.mem_write = 1'b0;
         ctrl.branch    = 1'b0;
         ctrl.jump      = 1'b0;
      end
      if (ctrl.rd == 5'd0)
         ctrl.reg_write = 1'b0;
      ctrl.illegal = w_illegal;

      imm = XLEN'(w_imm32);
   end

endmodule

// File: rtl/control_decode_pipe.sv
// ----------------------------------------------------------------------------
// control_decode_pipe
//   Registered decode stage between fetch and execute. One instruction per
//   valid/ready handshake, one cycle of latency, flush for branch redirects.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     flush                    drop held output and any same-cycle input
//     in_valid/in_ready        fetch-side handshake (instr, pc_in)
//     out_valid/out_ready      execute-side handshake
//     pc_out                   registered pc_in
//     rs1/rs2/rd, imm          register indices and immediate
//     alu_op, alu_src_imm/pc   ALU control (alu_op is ctrl_pkg::alu_op_e)
//     reg_write, mem_*         write-back and memory control
//     branch/br_cond, jump     control-flow control
//     wb_sel, illegal          write-back select, unsupported instruction
// ----------------------------------------------------------------------------
module control_decode_pipe
   import ctrl_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int EN_MEXT = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] pc_out,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] imm,
   output logic [4:0]      alu_op,
   output logic            alu_src_imm,
   output logic            alu_src_pc,
   output logic            reg_write,
   output logic            mem_read,
   output logic            mem_write,
   output logic [2:0]      mem_size,
   output logic            branch,
   output logic [2:0]      br_cond,
   output logic            jump,
   output logic [1:0]      wb_sel,
   output logic            illegal
);

   pipe_state_e     r_state;
   ctrl_word_t      r_ctrl;
   logic [XLEN-1:0] r_imm;
   logic [XLEN-1:0] r_pc;

   ctrl_word_t      w_ctrl;
   logic [XLEN-1:0] w_imm;
   logic            w_accept;

   control_decode_comb #(
      .XLEN    (XLEN),
      .EN_MEXT (EN_MEXT)
   ) u_decode (
      .instr (instr),
      .ctrl  (w_ctrl),
      .imm   (w_imm)
   );

   // Held in reset so fetch sees no acceptance until reset is released.
   assign in_ready = !rst && ((r_state == ST_EMPTY) || out_ready);
   assign w_accept = in_valid && in_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values and block ordering cannot change behaviour.
      if (rst) begin
         // NOTE: the data registers are reset too, not just the valid bit,
         // because every output must read 0 while in reset.
         r_state <= ST_EMPTY;
         r_ctrl  <= '0;
         r_imm   <= '0;
         r_pc    <= '0;
      end else if (flush) begin
         r_state <= ST_EMPTY;
      end else if (w_accept) begin
         r_state <= ST_FULL;
         r_ctrl  <= w_ctrl;
         r_imm   <= w_imm;
         r_pc    <= pc_in;
      end else if (out_ready) begin
         // Drain: data fields keep their stale value, only validity drops.
         r_state <= ST_EMPTY;
      end
   end

   assign out_valid   = (r_state == ST_FULL);
   assign pc_out      = r_pc;
   assign imm         = r_imm;
   assign rs1         = r_ctrl.rs1;
   assign rs2         = r_ctrl.rs2;
   assign rd          = r_ctrl.rd;
   assign alu_op      = r_ctrl.alu_op;
   assign alu_src_imm = r_ctrl.alu_src_imm;
   assign alu_src_pc  = r_ctrl.alu_src_pc;
   assign reg_write   = r_ctrl.reg_write;
   assign mem_read    = r_ctrl.mem_read;
   assign mem_write   = r_ctrl.mem_write;
   assign mem_size    = r_ctrl.mem_size;
   assign branch      = r_ctrl.branch;
   assign br_cond     = r_ctrl.br_cond;
   assign jump        = r_ctrl.jump;
   assign wb_sel      = r_ctrl.wb_sel;
   assign illegal     = r_ctrl.illegal;

endmodule
